// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI mode-0 (CPOL=0, CPHA=0) responder.
// It oversamples the SPI pins in the clk_i domain. Received words leave on an
// RX valid/ready stream. Words to transmit are popped from a TX valid/ready stream.
// Optional build macro: SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting in both
// directions. Without it, words are shifted MSB first.
module spi_slave_stream #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sclk_i,
    input  logic                  cs_ni,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic                  tx_valid_i,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  tx_ready_o,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    input  logic                  rx_ready_i,
    output logic                  busy_o,
    output logic                  underrun_o,
    output logic                  overrun_o,
    output logic                  frame_err_o
);

    localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-2:0]   rx_shift;

    logic [SYNC_STAGES-1:0]  sclk_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic                    sclk_q;
    logic                    cs_q;

    logic                    sclk_s;
    logic                    cs_s;
    logic                    mosi_s;
    logic                    sclk_rise;
    logic                    sclk_fall;
    logic                    cs_rise;
    logic                    cs_fall;

    logic                    load_now;
    logic [DATA_WIDTH-1:0]   load_word;
    logic [DATA_WIDTH-1:0]   tx_next;
    logic [DATA_WIDTH-1:0]   rx_word;
    logic [DATA_WIDTH-2:0]   rx_keep;
    logic                    miso_bit;

    // Synchronizer chains for the asynchronous pins, plus one delayed copy of the
    // last stage of SCLK and CS_N for edge detection. CS_N starts out deselected so
    // that leaving reset does not look like a select.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_ni};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    // Shift direction. The received word is formed from the stored bits and the
    // bit currently being sampled. This lets the completed word be handed to the
    // RX stream in the same cycle as its last rising edge.
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_word  = {mosi_s, rx_shift};
    assign rx_keep  = rx_word[DATA_WIDTH-1:1];
    assign tx_next  = {1'b0, tx_shift[DATA_WIDTH-1:1]};
    assign miso_bit = tx_shift[0];
`else
    assign rx_word  = {rx_shift, mosi_s};
    assign rx_keep  = rx_word[DATA_WIDTH-2:0];
    assign tx_next  = {tx_shift[DATA_WIDTH-2:0], 1'b0};
    assign miso_bit = tx_shift[DATA_WIDTH-1];
`endif

    // A TX word is taken on the first cycle after select, and again on the SCLK
    // fall that follows each completed word. A simultaneous CS release wins, so the
    // word is not popped.
    always_comb begin
        load_now = 1'b0;
        if (!cs_rise) begin
            if (state == LOAD) begin
                load_now = 1'b1;
            end else if (state == SHIFT && sclk_fall && bit_cnt == CNT_FULL) begin
                load_now = 1'b1;
            end
        end
        load_word = tx_valid_i ? tx_data_i : IDLE_WORD;
    end

    assign tx_ready_o = load_now & tx_valid_i;
    assign miso_o     = miso_oe_o & miso_bit;

    // Main transfer FSM. It also owns the RX holding register and the single-cycle
    // status pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            miso_oe_o   <= 1'b0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= '0;
            busy_o      <= 1'b0;
            underrun_o  <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            underrun_o  <= 1'b0;
            overrun_o   <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= ~cs_s;

            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            if (load_now) begin
                tx_shift   <= load_word;
                underrun_o <= ~tx_valid_i;
                bit_cnt    <= '0;
            end

            if (cs_rise) begin
                state       <= IDLE;
                miso_oe_o   <= 1'b0;
                bit_cnt     <= '0;
                rx_shift    <= '0;
                frame_err_o <= (bit_cnt != '0) && (bit_cnt != CNT_FULL);
            end else begin
                case (state)
                    IDLE: begin
                        if (cs_fall) begin
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        state     <= SHIFT;
                        miso_oe_o <= 1'b1;
                    end
                    SHIFT: begin
                        if (sclk_rise && bit_cnt != CNT_FULL) begin
                            rx_shift <= rx_keep;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_LAST) begin
                                if (!rx_valid_o || rx_ready_i) begin
                                    rx_data_o  <= rx_word;
                                    rx_valid_o <= 1'b1;
                                end else begin
                                    overrun_o <= 1'b1;
                                end
                            end
                        end else if (sclk_fall && bit_cnt != '0 && bit_cnt != CNT_FULL) begin
                            tx_shift <= tx_next;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_stream.sv
// tb_spi_slave_stream: randomized, self-checking bench for spi_slave_stream with
// 8-bit words. A word-level reference model predicts the expected results:
// - which TX word (or the idle word) appears on MISO for every word slot;
// - which RX words reach the consumer;
// - how many pops, underruns, overruns and frame errors occur.
// The bench models SPI_SLAVE_LSB_FIRST_EN the same way as the design.
module tb_spi_slave_stream;

    localparam int          DW        = 8;
    localparam int          HALF      = 8;
    localparam logic [7:0]  IDLE_WORD = 8'h96;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam bit          LSB_FIRST = 1'b1;
`else
    localparam bit          LSB_FIRST = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          sclk_i;
    logic          cs_ni;
    logic          mosi_i;
    logic          miso_o;
    logic          miso_oe_o;
    logic          tx_valid_i = 1'b0;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_ready_o;
    logic          rx_valid_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_ready_i;
    logic          busy_o;
    logic          underrun_o;
    logic          overrun_o;
    logic          frame_err_o;

    spi_slave_stream #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(2),
        .IDLE_WORD  (IDLE_WORD)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sclk_i     (sclk_i),
        .cs_ni      (cs_ni),
        .mosi_i     (mosi_i),
        .miso_o     (miso_o),
        .miso_oe_o  (miso_oe_o),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_ready_o (tx_ready_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .rx_ready_i (rx_ready_i),
        .busy_o     (busy_o),
        .underrun_o (underrun_o),
        .overrun_o  (overrun_o),
        .frame_err_o(frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations collected by the stream monitor
    int            n_ready = 0;
    int            n_under = 0;
    int            n_over  = 0;
    int            n_ferr  = 0;
    logic [DW-1:0] rx_got[$];
    int            tx_head = 0;

    // TX stream contents and reference model state
    logic [DW-1:0] tx_mem[$];
    int            model_head = 0;
    bit            model_held = 1'b0;
    logic [DW-1:0] exp_held;
    logic [DW-1:0] exp_miso[$];
    logic [DW-1:0] exp_rx[$];
    int            exp_pops;
    int            exp_under;
    int            exp_over;

    // Master-side capture
    logic [DW-1:0] mosi_words[$];
    logic [DW-1:0] miso_words[$];
    int            oe_low_bits;
    int            busy_low_bits;
    logic [15:0]   rst_snap;

    // Baselines taken before each scenario
    int b_ready, b_under, b_over, b_ferr, b_rx;

    // Stream monitor and TX source. On each falling clk edge it counts status
    // pulses and records RX words being accepted. It advances the TX stream after
    // a handshake has completed.
    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_ready_o === 1'b1) n_ready++;
            if (underrun_o === 1'b1) n_under++;
            if (overrun_o === 1'b1) n_over++;
            if (frame_err_o === 1'b1) n_ferr++;
            if (rx_valid_o === 1'b1 && rx_ready_i) rx_got.push_back(rx_data_o);
            if (tx_valid_i && tx_ready_o === 1'b1) begin
                @(posedge clk_i);
                #1;
                tx_head++;
            end
            tx_valid_i = (tx_head < tx_mem.size());
            tx_data_i  = tx_valid_i ? tx_mem[tx_head] : '0;
        end
    end

    function automatic int bit_pos(input int j);
        return LSB_FIRST ? j : DW - 1 - j;
    endfunction

    task automatic mark();
        b_ready = n_ready;
        b_under = n_under;
        b_over  = n_over;
        b_ferr  = n_ferr;
        b_rx    = rx_got.size();
    endtask

    task automatic queue_tx(input logic [DW-1:0] w);
        tx_mem.push_back(w);
    endtask

    // Word-level model. Every word slot that is started takes the next queued TX
    // word or, if none is queued, the idle word. Every fully clocked word is
    // delivered to the consumer, held, or dropped as an overrun.
    task automatic model_frame(input int n_starts, input int n_full);
        exp_miso.delete();
        exp_rx.delete();
        exp_pops  = 0;
        exp_under = 0;
        exp_over  = 0;
        for (int i = 0; i < n_starts; i++) begin
            if (model_head < tx_mem.size()) begin
                exp_miso.push_back(tx_mem[model_head]);
                model_head++;
                exp_pops++;
            end else begin
                exp_miso.push_back(IDLE_WORD);
                exp_under++;
            end
        end
        for (int i = 0; i < n_full; i++) begin
            if (rx_ready_i) exp_rx.push_back(mosi_words[i]);
            else if (!model_held) begin
                model_held = 1'b1;
                exp_held   = mosi_words[i];
            end else exp_over++;
        end
    endtask

    // Mode-0 SPI master. It clocks n_bits bits from mosi_words and samples MISO on
    // each rising edge. The last falling edge coincides with CS release, unless the
    // frame is cut short by a reset.
    task automatic spi_frame(input int n_bits, input bit reset_end);
        logic [DW-1:0] w;
        logic [DW-1:0] cap;
        cap = '0;
        miso_words.delete();
        oe_low_bits   = 0;
        busy_low_bits = 0;
        @(negedge clk_i);
        w      = mosi_words[0];
        cs_ni  = 1'b0;
        mosi_i = w[bit_pos(0)];
        repeat (HALF) @(negedge clk_i);
        for (int b = 0; b < n_bits; b++) begin
            sclk_i = 1'b1;
            cap[bit_pos(b % DW)] = miso_o;
            if (miso_oe_o !== 1'b1) oe_low_bits++;
            if (busy_o !== 1'b1) busy_low_bits++;
            if (b % DW == DW - 1) miso_words.push_back(cap);
            repeat (HALF) @(negedge clk_i);
            sclk_i = 1'b0;
            if (b == n_bits - 1) begin
                if (!reset_end) cs_ni = 1'b1;
            end else begin
                w      = mosi_words[(b + 1) / DW];
                mosi_i = w[bit_pos((b + 1) % DW)];
            end
            repeat (HALF) @(negedge clk_i);
        end
        if (reset_end) begin
            rst_i = 1'b1;
            #1;
            rst_snap = {miso_o, miso_oe_o, tx_ready_o, rx_valid_o, busy_o,
                        underrun_o, overrun_o, frame_err_o, rx_data_o};
            cs_ni = 1'b1;
            repeat (4) @(negedge clk_i);
            rst_i = 1'b0;
        end
        mosi_i = 1'b0;
        repeat (2 * HALF) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; sclk_i = 1'b0; cs_ni = 1'b1; mosi_i = 1'b0; rx_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_checks++; if ({miso_o, miso_oe_o, tx_ready_o, rx_valid_o} !== 4'b0) $display("[TB] FAIL reset_ctrl: got %b expected 0000", {miso_o, miso_oe_o, tx_ready_o, rx_valid_o}); else n_pass++;
        n_checks++; if (rx_data_o !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data_o); else n_pass++;
        n_checks++; if ({busy_o, underrun_o, overrun_o, frame_err_o} !== 4'b0) $display("[TB] FAIL reset_status: got %b expected 0000", {busy_o, underrun_o, overrun_o, frame_err_o}); else n_pass++;
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);
        n_checks++; if ({busy_o, miso_oe_o} !== 2'b00) $display("[TB] FAIL idle_after_reset: got %b expected 00", {busy_o, miso_oe_o}); else n_pass++;
    endtask

    task automatic test_single_word();
        mark();
        queue_tx(8'hA5);
        mosi_words = '{8'h3C};
        model_frame(1, 1);
        spi_frame(DW, 1'b0);
        n_checks++; if (miso_words[0] !== exp_miso[0]) $display("[TB] FAIL single_miso: got %h expected %h", miso_words[0], exp_miso[0]); else n_pass++;
        n_checks++; if (oe_low_bits + busy_low_bits != 0) $display("[TB] FAIL single_oe_busy: got %0d low samples expected 0", oe_low_bits + busy_low_bits); else n_pass++;
        n_checks++; if (n_ready - b_ready != exp_pops) $display("[TB] FAIL single_pops: got %0d expected %0d", n_ready - b_ready, exp_pops); else n_pass++;
        n_checks++; if (rx_got.size() - b_rx != 1 || rx_got[b_rx] !== exp_rx[0]) $display("[TB] FAIL single_rx: got %0d words expected 1 word %h", rx_got.size() - b_rx, exp_rx[0]); else n_pass++;
        n_checks++; if ({miso_oe_o, busy_o, rx_valid_o} !== 3'b000) $display("[TB] FAIL single_end: got %b expected 000", {miso_oe_o, busy_o, rx_valid_o}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        mark();
        queue_tx(8'h81);
        queue_tx(8'h42);
        mosi_words = '{8'h11, 8'h22};
        model_frame(2, 2);
        spi_frame(2 * DW, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (miso_words[i] !== exp_miso[i]) $display("[TB] FAIL b2b_miso%0d: got %h expected %h", i, miso_words[i], exp_miso[i]); else n_pass++;
            n_checks++; if (rx_got.size() <= b_rx + i || rx_got[b_rx + i] !== exp_rx[i]) $display("[TB] FAIL b2b_rx%0d: got %0d words expected word %h", i, rx_got.size() - b_rx, exp_rx[i]); else n_pass++;
        end
        n_checks++; if (n_ready - b_ready != exp_pops) $display("[TB] FAIL b2b_pops: got %0d expected %0d", n_ready - b_ready, exp_pops); else n_pass++;
        n_checks++; if (n_ferr - b_ferr != 0 || n_under - b_under != 0) $display("[TB] FAIL b2b_flags: got ferr %0d under %0d expected 0 0", n_ferr - b_ferr, n_under - b_under); else n_pass++;
    endtask

    task automatic test_underrun();
        mark();
        mosi_words = '{8'hFF};
        model_frame(1, 1);
        spi_frame(DW, 1'b0);
        n_checks++; if (miso_words[0] !== exp_miso[0]) $display("[TB] FAIL underrun_miso: got %h expected %h", miso_words[0], exp_miso[0]); else n_pass++;
        n_checks++; if (n_under - b_under != exp_under) $display("[TB] FAIL underrun_count: got %0d expected %0d", n_under - b_under, exp_under); else n_pass++;
        n_checks++; if (n_ready - b_ready != 0) $display("[TB] FAIL underrun_pops: got %0d expected 0", n_ready - b_ready); else n_pass++;
        n_checks++; if (rx_got.size() - b_rx != 1 || rx_got[b_rx] !== exp_rx[0]) $display("[TB] FAIL underrun_rx: got %0d words expected word %h", rx_got.size() - b_rx, exp_rx[0]); else n_pass++;
    endtask

    task automatic test_overrun();
        mark();
        rx_ready_i = 1'b0;
        mosi_words = '{8'h01, 8'h02};
        model_frame(2, 2);
        spi_frame(2 * DW, 1'b0);
        n_checks++; if ({rx_valid_o, rx_data_o} !== {1'b1, exp_held}) $display("[TB] FAIL overrun_hold: got %b/%h expected 1/%h", rx_valid_o, rx_data_o, exp_held); else n_pass++;
        n_checks++; if (n_over - b_over != exp_over) $display("[TB] FAIL overrun_count: got %0d expected %0d", n_over - b_over, exp_over); else n_pass++;
        n_checks++; if (rx_got.size() != b_rx) $display("[TB] FAIL overrun_no_accept: got %0d words expected 0", rx_got.size() - b_rx); else n_pass++;
        rx_ready_i = 1'b1;
        model_held = 1'b0;
        repeat (4) @(negedge clk_i);
        n_checks++; if (rx_got.size() - b_rx != 1 || rx_got[b_rx] !== exp_held || rx_valid_o !== 1'b0) $display("[TB] FAIL overrun_drain: got %0d words valid %b expected 1 word %h", rx_got.size() - b_rx, rx_valid_o, exp_held); else n_pass++;
    endtask

    task automatic test_abort();
        mark();
        queue_tx(8'h3A);
        mosi_words = '{8'hB7};
        model_frame(1, 0);
        spi_frame(3, 1'b0);
        n_checks++; if (n_ferr - b_ferr != 1) $display("[TB] FAIL abort_ferr: got %0d expected 1", n_ferr - b_ferr); else n_pass++;
        n_checks++; if (rx_valid_o !== 1'b0 || rx_got.size() != b_rx) $display("[TB] FAIL abort_rx: got valid %b words %0d expected 0 0", rx_valid_o, rx_got.size() - b_rx); else n_pass++;
        n_checks++; if (n_ready - b_ready != exp_pops || miso_oe_o !== 1'b0) $display("[TB] FAIL abort_pop_oe: got pops %0d oe %b expected %0d 0", n_ready - b_ready, miso_oe_o, exp_pops); else n_pass++;
        mark();
        queue_tx(8'hC4);
        mosi_words = '{8'h5D};
        model_frame(1, 1);
        spi_frame(DW, 1'b0);
        n_checks++; if (miso_words[0] !== exp_miso[0]) $display("[TB] FAIL abort_next_miso: got %h expected %h", miso_words[0], exp_miso[0]); else n_pass++;
        n_checks++; if (rx_got.size() - b_rx != 1 || rx_got[b_rx] !== exp_rx[0] || n_ferr != b_ferr) $display("[TB] FAIL abort_next_rx: got %0d words ferr %0d expected 1 word %h ferr 0", rx_got.size() - b_rx, n_ferr - b_ferr, exp_rx[0]); else n_pass++;
    endtask

    task automatic test_reset_mid_word();
        mark();
        queue_tx(8'h77);
        mosi_words = '{8'hE1};
        model_frame(1, 0);
        spi_frame(4, 1'b1);
        n_checks++; if (rst_snap !== 16'h0000) $display("[TB] FAIL midreset_outputs: got %h expected 0000", rst_snap); else n_pass++;
        n_checks++; if (rx_got.size() != b_rx || n_ferr != b_ferr) $display("[TB] FAIL midreset_drop: got words %0d ferr %0d expected 0 0", rx_got.size() - b_rx, n_ferr - b_ferr); else n_pass++;
        mark();
        queue_tx(8'h2B);
        mosi_words = '{8'h94};
        model_frame(1, 1);
        spi_frame(DW, 1'b0);
        n_checks++; if (miso_words[0] !== exp_miso[0]) $display("[TB] FAIL midreset_next_miso: got %h expected %h", miso_words[0], exp_miso[0]); else n_pass++;
        n_checks++; if (rx_got.size() - b_rx != 1 || rx_got[b_rx] !== exp_rx[0]) $display("[TB] FAIL midreset_next_rx: got %0d words expected word %h", rx_got.size() - b_rx, exp_rx[0]); else n_pass++;
    endtask

    task automatic test_random();
        int nw;
        int nt;
        for (int it = 0; it < 8; it++) begin
            mark();
            nw = $urandom_range(1, 3);
            nt = $urandom_range(0, 3);
            for (int k = 0; k < nt; k++) queue_tx(DW'($urandom));
            mosi_words.delete();
            for (int k = 0; k < nw; k++) mosi_words.push_back(DW'($urandom));
            model_frame(nw, nw);
            spi_frame(nw * DW, 1'b0);
            for (int k = 0; k < nw; k++) begin
                n_checks++; if (miso_words[k] !== exp_miso[k]) $display("[TB] FAIL rand%0d_miso%0d: got %h expected %h", it, k, miso_words[k], exp_miso[k]); else n_pass++;
                n_checks++; if (rx_got.size() <= b_rx + k || rx_got[b_rx + k] !== exp_rx[k]) $display("[TB] FAIL rand%0d_rx%0d: got %0d words expected word %h", it, k, rx_got.size() - b_rx, exp_rx[k]); else n_pass++;
            end
            n_checks++; if (n_ready - b_ready != exp_pops || n_under - b_under != exp_under) $display("[TB] FAIL rand%0d_pops: got pops %0d under %0d expected %0d %0d", it, n_ready - b_ready, n_under - b_under, exp_pops, exp_under); else n_pass++;
            n_checks++; if (n_over != b_over || n_ferr != b_ferr || oe_low_bits != 0) $display("[TB] FAIL rand%0d_flags: got over %0d ferr %0d oe_low %0d expected 0 0 0", it, n_over - b_over, n_ferr - b_ferr, oe_low_bits); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_overrun();
        test_abort();
        test_reset_mid_word();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
